// File: rtl/parity_rx_bdeduffy.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Samples one bit per bit_en strobe and presents each word through a one-entry valid/ready buffer.
module parity_rx_bdeduffy #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdi,
    input  logic              bit_en,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned      CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0]  LastCnt = CntW'(DATA_W - 1);
    localparam logic             OddInit = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                acc_q, acc_d;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_out_q, perr_out_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;
        ovr_d      = 1'b0;

        // A handshake frees the buffer; a load in the same cycle re-asserts valid below.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            unique case (state_q)
                StIdle: begin
                    if (!sdi) begin
                        state_d = StData;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                StData: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CntW'(i)) begin
                            shift_d[i] = sdi;
                        end
                    end
                    acc_d = acc_q ^ sdi;
                    if (cnt_q == LastCnt) begin
                        state_d = StParity;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    perr_d  = acc_q ^ sdi ^ OddInit;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!valid_q || out_ready) begin
                        data_d     = shift_q;
                        perr_out_d = perr_q;
                        ferr_d     = ~sdi;
                        valid_d    = 1'b1;
                    end else begin
                        // Buffer still held: drop the frame, keep the old word visible.
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign out_valid  = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/parity_rx_bdeduffy.md
Name: parity_rx_bdeduffy

Overview:
- Serial frame receiver that checks parity of each incoming frame, the receiving end of our 9-bit parity-generated byte link.
- Frame: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1); line idles high.
- One bit is sampled per `bit_en` pulse from an upstream baud/strobe generator. This block does no oversampling.
- The received word and its parity/framing status are held in a one-entry output buffer with a valid/ready handshake.

Parameters:
- DATA_W, 8: data bits per frame (legal range 1..16).
- ODD_PARITY, 0: 0 means even parity (the total count of ones over data plus parity bit must be even); 1 means odd parity.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- sdi  input  1  serial data in; already synchronised to clk; idles high.
- bit_en  input  1  one-cycle strobe; sdi is sampled only on cycles where bit_en=1.
- out_ready  input  1  consumer accepts the buffered word when out_valid=1 and out_ready=1.
- data_out  output  DATA_W  received data word, bit 0 = first data bit received.
- out_valid  output  1  buffer holds an unconsumed word.
- parity_err  output  1  parity check failed for the word in data_out.
- frame_err  output  1  stop bit sampled as 0 for the word in data_out.
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the buffer was full.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state goes to IDLE.
  - data_out=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Internal shift register, bit counter and parity accumulator are cleared.
  - Reset mid-frame abandons the frame with no output. Reset also overrides every other event in the same cycle.
- State machine (all transitions occur only on cycles with bit_en=1, except reset):
  - IDLE: if sdi=0, go to DATA, clear bit count and parity accumulator. If sdi=1, stay in IDLE.
  - DATA: shift sdi into position bit_cnt, accumulate parity (acc ^= sdi), increment bit_cnt. After the DATA_W-th data bit, go to PARITY.
  - PARITY: compute perr = acc ^ sdi ^ ODD_PARITY and latch it internally. Go to STOP.
  - STOP: go to IDLE and attempt to load the frame into the buffer (see below). A stop bit of 0 sets frame_err for that word; there is no resync or hunting.
  - bit_en=0 cycles hold all state.
- Start bit is a single sample. No false-start rejection.
- Buffer load, on the clk edge ending the STOP sample:
  - Buffer free (out_valid=0), or being consumed this cycle (out_valid=1 and out_ready=1): load data_out, parity_err, frame_err together and set out_valid=1. Data is visible the next cycle.
  - Buffer full and not consumed (out_valid=1, out_ready=0): drop the frame. data_out, parity_err and frame_err keep the old word. overrun=1 for exactly the next cycle.
- Consume with no load in the same cycle: out_valid goes to 0 next cycle. data_out, parity_err and frame_err hold their last values.
- Latency: out_valid rises 1 clk after the bit_en cycle that samples the stop bit.
- Back-to-back frames are allowed: a start bit may be sampled on the bit_en immediately after the stop bit.
- The receiver keeps receiving while out_valid=1. It never stalls the line.
- busy=1 in DATA, PARITY and STOP.

Test Plan:
- Reset, then sdi=1 with bit_en pulsing for 20 strobes: out_valid=0, busy=0, state remains IDLE; all outputs 0.
- ODD_PARITY=0, send 0xA5 (serial order 0,1,0,1,0,0,1,0,1,p=0,1), out_ready=1: out_valid pulses 1 cycle after the stop sample; data_out=0xA5, parity_err=0, frame_err=0. Repeat with p=1: parity_err=1.
- ODD_PARITY=1, send 0x07 with p=0: parity_err=0. Send 0x00 with p=0: parity_err=1. Send 0xFF with stop bit=0: frame_err=1, data_out=0xFF.
- out_ready=0, send 0x3C then 0xC3 back-to-back: first word is held as data_out=0x3C. After the second stop sample, overrun=1 for one cycle and data_out stays 0x3C. Raise out_ready and out_valid drops.
- Hold out_ready=1 only on the exact cycle the second frame loads (out_valid=1 from the first frame): new word 0xC3 is loaded, out_valid stays 1, overrun stays 0.
- Assert rst during the 4th data bit of a frame, then deassert: out_valid=0, busy=0. A following clean frame 0x5A is received correctly with no errors.
